// File: rtl/seq_pkg.sv
// seq_pkg -- shared definition of the 8-byte repeating sequence.
//
// Used by both the sequence generator and sequence_checker so the two blocks
// can never disagree about the pattern.
//   SEQ_LEN  : number of bytes in one frame
//   SEQ_ROM  : the frame contents, index 0 first
//   idx_t    : byte index within a frame (mod SEQ_LEN)
//   state_t  : checker alignment state
package seq_pkg;

  localparam int SEQ_LEN = 8;

  typedef logic [2:0] idx_t;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [7:0] SEQ_ROM [SEQ_LEN] = '{
    8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D
  };

  function automatic logic [7:0] seq_byte(input idx_t i);
    return SEQ_ROM[i];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter -- up counter that sticks at all-ones.
//
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, clears the count
//   clr   : synchronous clear, wins over a same-cycle inc
//   inc   : add one this cycle unless already saturated
//   cnt   : current count, W bits
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/sequence_checker.sv
// sequence_checker -- aligns to and tracks the 8-byte generator pattern.
//
// Hunts for 0xAF, tracks the sequence until LOCK_COUNT consecutive bytes
// match, then stays locked (flywheeling through isolated errors) until
// MISS_LIMIT consecutive mismatches. Completed frames while locked are counted.
//
// Handshake: data_in is consumed on every rising edge where valid_in is high;
// there is no back-pressure. Every output is registered and reflects the byte
// consumed at the preceding edge.
//
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   valid_in       : data_in is sampled this cycle
//   data_in [7:0]  : byte from the generator
//   locked         : high while in LOCKED
//   mismatch       : one-cycle pulse, compared byte was wrong
//   frame_done     : one-cycle pulse, index 7 consumed and still locked
//   seq_idx [2:0]  : index of the next expected byte
//   expected [7:0] : SEQ_ROM[seq_idx]
//   frame_cnt      : saturating count of completed locked frames
//   err_clr, err_cnt[15:0] : only with SEQ_CHECK_ERRCNT_EN defined; saturating
//                    mismatch counter with synchronous clear
//   state_dbg      : current alignment state, for observation
module sequence_checker
  import seq_pkg::*;
#(
  parameter int LOCK_COUNT = 8,
  parameter int MISS_LIMIT = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [7:0]       data_in,
  output logic             locked,
  output logic             mismatch,
  output logic             frame_done,
  output idx_t             seq_idx,
  output logic [7:0]       expected,
  output logic [CNT_W-1:0] frame_cnt,
`ifdef SEQ_CHECK_ERRCNT_EN
  input  logic             err_clr,
  output logic [15:0]      err_cnt,
`endif
  output state_t           state_dbg
);

  localparam logic [7:0] LOCK_N = LOCK_COUNT[7:0];
  localparam logic [3:0] MISS_N = MISS_LIMIT[3:0];

  state_t     state_q, state_n;
  idx_t       idx_q, idx_n;
  logic [7:0] run_q, run_n;
  logic [3:0] miss_q, miss_n;
  logic       mm_n, fd_n, hit;

  assign hit       = (data_in == seq_byte(idx_q));
  assign seq_idx   = idx_q;
  assign state_dbg = state_q;

  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    run_n   = run_q;
    miss_n  = miss_q;
    mm_n    = 1'b0;
    fd_n    = 1'b0;
    if (valid_in) begin
      case (state_q)
        HUNT: begin
          // Align on 0xAF only; the repeated 0xE2 would be ambiguous.
          if (data_in == seq_byte(3'd0)) begin
            state_n = TRACK;
            idx_n   = 3'd1;
            run_n   = 8'd1;
          end
        end
        TRACK: begin
          if (hit) begin
            idx_n = idx_q + 3'd1;
            run_n = run_q + 8'd1;
            if (run_q + 8'd1 == LOCK_N) begin
              state_n = LOCKED;
              miss_n  = 4'd0;
            end
          end else begin
            mm_n = 1'b1;
            if (data_in == seq_byte(3'd0)) begin
              idx_n = 3'd1;
              run_n = 8'd1;
            end else begin
              state_n = HUNT;
              idx_n   = 3'd0;
              run_n   = 8'd0;
            end
          end
        end
        LOCKED: begin
          // Flywheel: the index advances whether or not the byte matched.
          idx_n = idx_q + 3'd1;
          if (hit) begin
            miss_n = 4'd0;
          end else begin
            mm_n   = 1'b1;
            miss_n = miss_q + 4'd1;
          end
          if (!hit && (miss_q + 4'd1 == MISS_N)) begin
            state_n = HUNT;
            idx_n   = 3'd0;
            run_n   = 8'd0;
            miss_n  = 4'd0;
          end else if (idx_q == 3'd7) begin
            fd_n = 1'b1;
          end
        end
        default: begin
          state_n = HUNT;
          idx_n   = 3'd0;
          run_n   = 8'd0;
          miss_n  = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= HUNT;
      idx_q      <= 3'd0;
      run_q      <= 8'd0;
      miss_q     <= 4'd0;
      locked     <= 1'b0;
      mismatch   <= 1'b0;
      frame_done <= 1'b0;
      expected   <= seq_byte(3'd0);
    end else begin
      state_q    <= state_n;
      idx_q      <= idx_n;
      run_q      <= run_n;
      miss_q     <= miss_n;
      locked     <= (state_n == LOCKED);
      mismatch   <= mm_n;
      frame_done <= fd_n;
      expected   <= seq_byte(idx_n);
    end
  end

  sat_counter #(.W(CNT_W)) u_frame_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (fd_n),
    .cnt   (frame_cnt)
  );

`ifdef SEQ_CHECK_ERRCNT_EN
  sat_counter #(.W(16)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (err_clr),
    .inc   (mm_n),
    .cnt   (err_cnt)
  );
`endif

endmodule

// File: tb/tb_sequence_checker.sv
// tb_sequence_checker -- directed scenarios plus randomized traffic against
// a frame-level reference model of the checker.
module tb_sequence_checker;
  import seq_pkg::*;

  localparam int LOCK_COUNT = 8;
  localparam int MISS_LIMIT = 3;
  localparam int CNT_W      = 4;
  localparam int FRAME_MAX  = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset = 1'b1;
  logic             valid_in = 1'b0;
  logic [7:0]       data_in = 8'h00;
  logic             err_clr = 1'b0;
  logic             locked, mismatch, frame_done;
  idx_t             seq_idx;
  logic [7:0]       expected;
  logic [CNT_W-1:0] frame_cnt;
  state_t           state_dbg;
`ifdef SEQ_CHECK_ERRCNT_EN
  logic [15:0]      err_cnt;
`endif

  sequence_checker #(
    .LOCK_COUNT (LOCK_COUNT),
    .MISS_LIMIT (MISS_LIMIT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .data_in    (data_in),
    .locked     (locked),
    .mismatch   (mismatch),
    .frame_done (frame_done),
    .seq_idx    (seq_idx),
    .expected   (expected),
    .frame_cnt  (frame_cnt),
`ifdef SEQ_CHECK_ERRCNT_EN
    .err_clr    (err_clr),
    .err_cnt    (err_cnt),
`endif
    .state_dbg  (state_dbg)
  );

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Described as "where in the frame are we, how sure are we":
  // aligned = a candidate alignment exists, m_lock = confirmed alignment.
  logic [7:0] pattern [8] = '{8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D};
  bit aligned = 0, m_lock = 0, m_mm = 0, m_fd = 0;
  int pos = 0, streak = 0, misses = 0, frames = 0, m_err = 0;

  always @(posedge clk) begin
    bit good;
    m_mm = 0;
    m_fd = 0;
    if (reset) begin
      aligned = 0; m_lock = 0; pos = 0; streak = 0; misses = 0; frames = 0; m_err = 0;
    end else begin
      if (valid_in) begin
        good = (data_in == pattern[pos]);
        if (m_lock) begin
          m_mm   = !good;
          misses = good ? 0 : misses + 1;
          if (misses == MISS_LIMIT) begin
            m_lock = 0; aligned = 0; pos = 0; streak = 0; misses = 0;
          end else begin
            if (pos == 7) begin
              m_fd = 1;
              frames = (frames < FRAME_MAX) ? frames + 1 : frames;
            end
            pos = (pos + 1) % 8;
          end
        end else if (aligned) begin
          if (good) begin
            pos = (pos + 1) % 8;
            streak++;
            if (streak == LOCK_COUNT) begin
              aligned = 0; m_lock = 1; misses = 0;
            end
          end else begin
            m_mm = 1;
            if (data_in == 8'hAF) begin
              pos = 1; streak = 1;
            end else begin
              aligned = 0; pos = 0; streak = 0;
            end
          end
        end else if (data_in == 8'hAF) begin
          aligned = 1; pos = 1; streak = 1;
        end
      end
      if (err_clr) m_err = 0;
      else if (m_mm && m_err < 65535) m_err++;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (started) begin
      chk("locked", {31'b0, locked}, {31'b0, m_lock});
      chk("mismatch", {31'b0, mismatch}, {31'b0, m_mm});
      chk("frame_done", {31'b0, frame_done}, {31'b0, m_fd});
      chk("seq_idx", {29'b0, seq_idx}, pos);
      chk("expected", {24'b0, expected}, {24'b0, pattern[pos]});
      chk("frame_cnt", {28'b0, frame_cnt}, frames);
      chk("state_locked", {31'b0, state_dbg == LOCKED}, {31'b0, m_lock});
      chk("state_track", {31'b0, state_dbg == TRACK}, {31'b0, aligned});
`ifdef SEQ_CHECK_ERRCNT_EN
      chk("err_cnt", {16'b0, err_cnt}, m_err);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic v, input logic [7:0] d);
    valid_in = v;
    data_in  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame();
    for (int i = 0; i < 8; i++) send(1'b1, pattern[i]);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    valid_in = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset(2);
    started = 1'b1;
    chk("rst_locked", {31'b0, locked}, 32'd0);
    chk("rst_expected", {24'b0, expected}, 32'hAF);
    chk("rst_seq_idx", {29'b0, seq_idx}, 32'd0);
    chk("rst_frame_cnt", {28'b0, frame_cnt}, 32'd0);

    // Acquire lock: lock rises on the 8th byte but no frame is counted.
    send_frame();
    chk("acq_locked", {31'b0, locked}, 32'd1);
    chk("acq_frame_cnt", {28'b0, frame_cnt}, 32'd0);
    chk("acq_seq_idx", {29'b0, seq_idx}, 32'd0);
    chk("acq_expected", {24'b0, expected}, 32'hAF);

    for (int f = 0; f < 3; f++) send_frame();
    chk("three_frames", {28'b0, frame_cnt}, 32'd3);

    // Single corrupted byte while locked: flywheel through it.
    send(1'b1, 8'hAF); send(1'b1, 8'hBC); send(1'b1, 8'hE2); send(1'b1, 8'h78);
    send(1'b1, 8'h00);
    chk("corrupt_mismatch", {31'b0, mismatch}, 32'd1);
    chk("corrupt_locked", {31'b0, locked}, 32'd1);
    send(1'b1, 8'hE2);
    chk("recover_mismatch", {31'b0, mismatch}, 32'd0);
    send(1'b1, 8'h0B); send(1'b1, 8'h8D);
    chk("four_frames", {28'b0, frame_cnt}, 32'd4);

    // Three misses in a row drop lock.
    send(1'b1, 8'h00); send(1'b1, 8'h00);
    chk("miss2_locked", {31'b0, locked}, 32'd1);
    send(1'b1, 8'h00);
    chk("miss3_locked", {31'b0, locked}, 32'd0);
    chk("miss3_seq_idx", {29'b0, seq_idx}, 32'd0);
    send(1'b1, 8'hAF); send(1'b1, 8'hBC);
    chk("realign_idx", {29'b0, seq_idx}, 32'd2);
    chk("realign_track", {31'b0, state_dbg == TRACK}, 32'd1);

    // Idle gap mid-frame.
    send(1'b1, 8'hE2); send(1'b1, 8'h78);
    for (int i = 0; i < 10; i++) send(1'b0, 8'h5A);
    chk("idle_seq_idx", {29'b0, seq_idx}, 32'd4);
    chk("idle_frame_cnt", {28'b0, frame_cnt}, 32'd4);
    send(1'b1, 8'hFF); send(1'b1, 8'hE2); send(1'b1, 8'h0B); send(1'b1, 8'h8D);
    chk("relock", {31'b0, locked}, 32'd1);
    chk("relock_frame_cnt", {28'b0, frame_cnt}, 32'd4);
    send_frame();
    chk("five_frames", {28'b0, frame_cnt}, 32'd5);
`ifdef SEQ_CHECK_ERRCNT_EN
    chk("err_cnt_four", {16'b0, err_cnt}, 32'd4);
`endif

    do_reset(1);
    chk("rst2_locked", {31'b0, locked}, 32'd0);
    chk("rst2_frame_cnt", {28'b0, frame_cnt}, 32'd0);
    chk("rst2_seq_idx", {29'b0, seq_idx}, 32'd0);
    chk("rst2_expected", {24'b0, expected}, 32'hAF);
    chk("rst2_mismatch", {31'b0, mismatch}, 32'd0);
`ifdef SEQ_CHECK_ERRCNT_EN
    chk("rst2_err_cnt", {16'b0, err_cnt}, 32'd0);
    send(1'b1, 8'hAF); send(1'b1, 8'h00);
    chk("err_cnt_one", {16'b0, err_cnt}, 32'd1);
    err_clr = 1'b1;
    send(1'b0, 8'h00);
    err_clr = 1'b0;
    chk("err_clr", {16'b0, err_cnt}, 32'd0);
`endif

    // Long clean run to saturate the narrow frame counter.
    send(1'b0, 8'h00);
    for (int f = 0; f < 20; f++) send_frame();
    chk("frame_sat", {28'b0, frame_cnt}, 32'd15);
    do_reset(1);
    chk("sat_reset", {28'b0, frame_cnt}, 32'd0);

    // Randomized traffic, biased toward the correct next byte.
    for (int n = 0; n < 4000; n++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 99);
      if (r < 75) b = pattern[pos];
      else if (r < 85) b = 8'hAF;
      else if (r < 90) b = 8'hE2;
      else b = 8'($urandom_range(0, 255));
      err_clr = ($urandom_range(0, 49) == 0);
      reset   = ($urandom_range(0, 299) == 0);
      send($urandom_range(0, 99) < 85, b);
      reset   = 1'b0;
      err_clr = 1'b0;
    end

    send(1'b0, 8'h00);
    started = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sequence_checker.md
Name: sequence_checker

Overview:
- Downstream consumer of the 8-byte sequence generator output.
- Aligns to the repeating pattern AF BC E2 78 FF E2 0B 8D and then tracks it byte by byte.
- Flags mismatches, declares and drops lock with hysteresis, and counts completed frames.
- Serves as the on-chip self-check monitor for the generator's data bus.

Parameters:
- LOCK_COUNT, 8: consecutive correct bytes (including the aligning 0xAF) needed to enter LOCKED; legal range 2..255.
- MISS_LIMIT, 3: consecutive mismatches in LOCKED that force return to HUNT; legal range 1..15.
- CNT_W, 16: width of frame_cnt.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high reset.
- valid_in, input, 1: data_in is sampled this cycle; normally the generator's enable.
- data_in, input, 8: byte from the generator.
- locked, output, 1: high while state == LOCKED.
- mismatch, output, 1: one-cycle pulse, byte compared and wrong.
- frame_done, output, 1: one-cycle pulse when byte index 7 is consumed while LOCKED.
- seq_idx, output, 3: index of the next expected byte.
- expected, output, 8: SEQ[seq_idx].
- frame_cnt, output, CNT_W: completed frames while LOCKED, saturating at all-ones.

Behaviour:
- All outputs are registered. Effect of a byte sampled at edge N is visible after edge N.
- Reset values: locked=0, mismatch=0, frame_done=0, seq_idx=0, expected=8'hAF, frame_cnt=0. State is HUNT, run=0, miss=0.
- Reset mid-operation discards all state on the next edge, including a saturated frame_cnt.
- Reset has priority over valid_in.
- Cycles with valid_in=0: state, idx and counters hold; mismatch and frame_done are 0.
- SEQ[0..7] = AF BC E2 78 FF E2 0B 8D. Index arithmetic is mod 8; 7 wraps to 0.
- HUNT:
  - valid & data==AF: go to TRACK, idx=1, run=1.
  - valid & other byte: stay in HUNT, no mismatch pulse.
- TRACK:
  - valid & data==SEQ[idx]: idx+1, run+1. If the new run == LOCK_COUNT, go to LOCKED, miss=0.
  - valid & mismatch: mismatch pulse. If data==AF, stay in TRACK with idx=1, run=1 (realign). Otherwise go to HUNT with idx=0, run=0.
- LOCKED:
  - valid & match: idx+1, miss=0.
  - valid & mismatch: mismatch pulse; idx still advances (flywheel); miss+1.
    - If miss reaches MISS_LIMIT, go to HUNT, idx=0, locked drops on the same edge.
  - Any valid byte consumed at idx==7 (match or miss), while state remains LOCKED after the edge: frame_done pulse, frame_cnt+1, saturating.
- The two E2 bytes (idx 2 and 5) are ambiguous. Alignment is on AF only, never on E2.
- run is 8 bits and miss is 4 bits; neither can overflow within the legal parameter ranges.

Optional Feature:
- Macro: SEQ_CHECK_ERRCNT_EN.
- When defined:
  - Adds output err_cnt [15:0], reset 0.
  - err_cnt increments on every mismatch pulse and saturates at 16'hFFFF.
  - Adds input err_clr [1], a synchronous clear with priority over a same-cycle increment.
- When undefined: the ports are absent and no counter logic exists.

Decomposition:
- Package seq_pkg holds:
  - SEQ_LEN=8 and the SEQ_ROM constant array of the 8 bytes;
  - the state enum {HUNT, TRACK, LOCKED};
  - the idx typedef logic [2:0].
- The generator shares this package so both blocks use one sequence definition.
- One natural sub-module: sat_counter (parameterised width, inc, clr, saturation). It is used for frame_cnt and err_cnt.

Test Plan:
- Reset, then feed 8 valid bytes AF..8D: locked rises after the 8th byte (idx 7 consumed). frame_done does not pulse and frame_cnt stays 0, because the state was TRACK when idx 7 was consumed. seq_idx=0, expected=AF.
- Continue with 3 clean frames: frame_done pulses 3 times, frame_cnt=3, mismatch never asserted.
- While locked, corrupt one byte (FF replaced by 00): one mismatch pulse, locked stays 1, the following byte 8'hE2 matches, miss returns to 0.
- While locked, send 3 consecutive 00 bytes: 3 mismatch pulses, locked falls on the 3rd, seq_idx=0. Then AF BC: state TRACK, seq_idx=2.
- Hold valid_in=0 for 10 cycles mid-frame: seq_idx and frame_cnt frozen, no pulses. Resume: tracking continues without error.
- Assert reset for 1 cycle while locked with frame_cnt=5: next cycle all outputs at reset values. With SEQ_CHECK_ERRCNT_EN defined, err_cnt=0 and err_clr clears a nonzero err_cnt the cycle after it is asserted.
